// File: rtl/memory_access_pkg.sv
// rtl/memory_access_pkg.sv - shared opcode, funct3, exception and FSM definitions for memory_access
package memory_access_pkg;

    localparam logic [4:0] OP_LOAD      = 5'b00000;
    localparam logic [4:0] OP_STORE     = 5'b01000;
    localparam logic [4:0] OP_IMM_ARITH = 5'b00100;
    localparam logic [4:0] OP_ARITH     = 5'b01100;
    localparam logic [4:0] OP_LUI       = 5'b01101;
    localparam logic [4:0] OP_AUIPC     = 5'b00101;
    localparam logic [4:0] OP_JAL       = 5'b11011;
    localparam logic [4:0] OP_JALR      = 5'b11001;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] EX_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] EX_STORE_MISALIGNED = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    // Any funct3 that is not a byte or half encoding is treated as a word access.
    function automatic mem_size_t access_size(input logic [2:0] funct);
        case (funct)
            F3_LB, F3_LBU: access_size = SZ_BYTE;
            F3_LH, F3_LHU: access_size = SZ_HALF;
            default:       access_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [4:0] opcode);
        writes_rd = (opcode == OP_ARITH) || (opcode == OP_IMM_ARITH) ||
                    (opcode == OP_LUI)   || (opcode == OP_AUIPC)     ||
                    (opcode == OP_JAL)   || (opcode == OP_JALR);
    endfunction

    function automatic logic [1:0] natural_lo(input logic [1:0] lo, input mem_size_t size);
        case (size)
            SZ_HALF: natural_lo = {lo[1], 1'b0};
            SZ_WORD: natural_lo = 2'b00;
            default: natural_lo = lo;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] lo, input mem_size_t size);
        case (size)
            SZ_HALF: is_misaligned = lo[0];
            SZ_WORD: is_misaligned = (lo != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/memory_access_mem_lane_align.sv
// rtl/memory_access_mem_lane_align.sv - byte-enable/store-replication and load lane extraction/extension
module mem_lane_align
    import memory_access_pkg::*;
(
    input  logic [2:0]  funct,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    mem_size_t   size;
    logic [31:0] shifted;

    always_comb begin
        size      = access_size(funct);
        shifted   = load_word >> {addr_lo, 3'b000};
        be        = 4'hF;
        wdata     = store_data;
        load_data = load_word;
        // funct[2] distinguishes the zero-extending LBU/LHU from LB/LH.
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = funct[2] ? {24'b0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                be        = 4'b0011 << addr_lo;
                wdata     = {2{store_data[15:0]}};
                load_data = funct[2] ? {16'b0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// rtl/memory_access.sv - memory access pipeline stage; optional MEM_MISALIGN_CHECK_EN traps misaligned accesses
module memory_access
    import memory_access_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int EX_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pipeline_in_valid,
    input  logic [4:0]            opcode_in,
    input  logic [2:0]            funct_in,
    input  logic [DATA_W-1:0]     result_in,
    input  logic [ADDR_W-1:0]     store_addr_in,
    input  logic [REG_ADDR_W-1:0] rd_addr_in,
    input  logic                  nop_instr_in,
    input  logic [EX_W-1:0]       exception_in,
    input  logic                  exception_in_valid,
    output logic                  stall_out,
    output logic                  dmem_req_valid,
    input  logic                  dmem_req_ready,
    output logic                  dmem_we,
    output logic [ADDR_W-1:0]     dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic                  dmem_rsp_valid,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  wb_valid,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_rd_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic [EX_W-1:0]       exception_out,
    output logic                  exception_out_valid
);

    state_t                state, state_next;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     data_q;
    logic [2:0]            funct_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  store_q;

    logic                  latch;
    logic                  acc_store;
    mem_size_t             acc_size;
    logic [ADDR_W-1:0]     acc_raw;
    logic [ADDR_W-1:0]     acc_addr;

    logic                  wb_valid_n, wb_en_n, exc_valid_n;
    logic [REG_ADDR_W-1:0] wb_rd_n;
    logic [DATA_W-1:0]     wb_data_n;
    logic [EX_W-1:0]       exc_n;

    logic [3:0]            lane_be;
    logic [31:0]           lane_wdata;
    logic [31:0]           lane_load;

    mem_lane_align u_lane (
        .funct      (funct_q),
        .addr_lo    (addr_q[1:0]),
        .store_data (data_q),
        .load_word  (dmem_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load)
    );

    assign stall_out = (state != ST_IDLE);

    // Request fields are driven from latched state only, so they stay stable until ready.
    assign dmem_req_valid = (state == ST_REQ);
    assign dmem_we        = (state == ST_REQ) && store_q;
    assign dmem_addr      = (state == ST_REQ) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign dmem_be        = (state == ST_REQ) ? lane_be : 4'h0;
    assign dmem_wdata     = (state == ST_REQ) ? lane_wdata : '0;

    always_comb begin
        state_next  = state;
        latch       = 1'b0;
        wb_valid_n  = 1'b0;
        wb_en_n     = 1'b0;
        wb_rd_n     = wb_rd_addr;
        wb_data_n   = wb_data;
        exc_n       = exception_out;
        exc_valid_n = 1'b0;

        acc_store = (opcode_in == OP_STORE);
        acc_size  = access_size(funct_in);
        acc_raw   = acc_store ? store_addr_in : result_in;
        acc_addr  = {acc_raw[ADDR_W-1:2], natural_lo(acc_raw[1:0], acc_size)};

        case (state)
            ST_IDLE: begin
                if (pipeline_in_valid) begin
                    if (!((opcode_in == OP_LOAD) || acc_store) || nop_instr_in || exception_in_valid) begin
                        wb_valid_n  = 1'b1;
                        wb_en_n     = writes_rd(opcode_in) && (rd_addr_in != '0) &&
                                      !nop_instr_in && !exception_in_valid;
                        wb_rd_n     = rd_addr_in;
                        wb_data_n   = result_in;
                        exc_n       = exception_in;
                        exc_valid_n = exception_in_valid;
`ifdef MEM_MISALIGN_CHECK_EN
                    end else if (is_misaligned(acc_raw[1:0], acc_size)) begin
                        wb_valid_n  = 1'b1;
                        wb_rd_n     = rd_addr_in;
                        wb_data_n   = acc_raw;
                        exc_n       = acc_store ? EX_W'(EX_STORE_MISALIGNED)
                                                : EX_W'(EX_LOAD_MISALIGNED);
                        exc_valid_n = 1'b1;
`endif
                    end else begin
                        latch      = 1'b1;
                        state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (dmem_req_ready) begin
                    if (store_q) begin
                        wb_valid_n = 1'b1;
                        wb_rd_n    = rd_q;
                        wb_data_n  = data_q;
                        exc_n      = '0;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_WAIT_RSP;
                    end
                end
            end
            ST_WAIT_RSP: begin
                if (dmem_rsp_valid) begin
                    wb_valid_n = 1'b1;
                    wb_en_n    = (rd_q != '0);
                    wb_rd_n    = rd_q;
                    wb_data_n  = lane_load;
                    exc_n      = '0;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= ST_IDLE;
            addr_q              <= '0;
            data_q              <= '0;
            funct_q             <= '0;
            rd_q                <= '0;
            store_q             <= 1'b0;
            wb_valid            <= 1'b0;
            wb_en               <= 1'b0;
            wb_rd_addr          <= '0;
            wb_data             <= '0;
            exception_out       <= '0;
            exception_out_valid <= 1'b0;
        end else begin
            state <= state_next;
            if (latch) begin
                addr_q  <= acc_addr;
                data_q  <= result_in;
                funct_q <= funct_in;
                rd_q    <= rd_addr_in;
                store_q <= acc_store;
            end
            wb_valid            <= wb_valid_n;
            wb_en               <= wb_en_n;
            wb_rd_addr          <= wb_rd_n;
            wb_data             <= wb_data_n;
            exception_out       <= exc_n;
            exception_out_valid <= exc_valid_n;
        end
    end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Pipeline stage directly downstream of execute.
- Consumes execute's registered outputs, issues load/store transactions on a valid/ready data-memory port, and aligns/extends load data.
- Presents one registered writeback record per instruction.
- Holds upstream via stall_out while a memory transaction is outstanding.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data/register width; fixed 32 for lane logic.
- REG_ADDR_W, 5, register index width.
- EX_W, 4, exception code width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- pipeline_in_valid  in  1  execute output valid.
- opcode_in  in  5  RV32I opcode[6:2].
- funct_in  in  3  funct3.
- result_in  in  DATA_W  load: effective address; store: store data; other ops: ALU result.
- store_addr_in  in  ADDR_W  store effective address.
- rd_addr_in  in  REG_ADDR_W  destination register.
- nop_instr_in  in  1  bubble marker.
- exception_in  in  EX_W  upstream exception code.
- exception_in_valid  in  1  upstream exception flag.
- stall_out  out  1  upstream must hold its outputs.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  memory accepts request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  ADDR_W  word-aligned address.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  DATA_W  lane-replicated store data.
- dmem_rsp_valid  in  1  load data valid.
- dmem_rdata  in  DATA_W  load word.
- wb_valid  out  1  writeback record valid.
- wb_en  out  1  register write required.
- wb_rd_addr  out  REG_ADDR_W  destination register.
- wb_data  out  DATA_W  writeback data.
- exception_out  out  EX_W  exception code.
- exception_out_valid  out  1  exception flag.

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0: wb_valid, wb_en, wb_rd_addr, wb_data, exception_out, exception_out_valid, dmem_* and stall_out.
- FSM states: IDLE, REQ, WAIT_RSP.
- stall_out = (state != IDLE), combinational.
- IDLE, pipeline_in_valid=1:
  - Non-memory op, nop, or exception_in_valid=1:
    - Registered pass-through next cycle: wb_valid=1, wb_data=result_in.
    - wb_en=1 only for ARITH/IMM_ARITH/LUI/AUIPC/JAL/JALR with rd≠0 and no nop/exception.
    - Exception fields are copied.
    - Latency 1 cycle.
  - LOAD or STORE: latch address, data, size and rd; go to REQ; wb_valid=0 next cycle.
- IDLE, pipeline_in_valid=0: wb_valid=0 next cycle.
- REQ:
  - dmem_req_valid=1; address, be, wdata and we held stable until dmem_req_ready.
  - On ready, load: go to WAIT_RSP.
  - On ready, store: emit wb_valid=1, wb_en=0; go to IDLE.
- WAIT_RSP:
  - On dmem_rsp_valid: emit wb_valid=1, wb_en=(rd≠0), wb_data=extended lane; go to IDLE.
- Load/store minimum latency, accept to wb_valid:
  - Load: 3 cycles (ready and rsp each in the first possible cycle).
  - Store: 2 cycles.
- Lanes, with a = addr[1:0]:
  - Byte ops (LB, LBU, SB): be = 1<<a.
  - Half ops (LH, LHU, SH): be = 2'b11<<a.
  - Word ops (LW, SW): be = 4'hF.
  - dmem_addr = {addr[ADDR_W-1:2], 2'b00}.
  - wdata replicates byte/half across all lanes.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Undefined funct3 handled as word.
- Boundaries:
  - pipeline_in_valid is ignored while state≠IDLE.
  - dmem_rsp_valid is ignored in IDLE/REQ.
  - reset in REQ/WAIT_RSP returns to IDLE and drops dmem_req_valid the next cycle; a late response is ignored.
  - Back-to-back mem ops are accepted on the first IDLE cycle.

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- With macro defined:
  - Misaligned access (half with a[0]=1; word with a≠0) issues no dmem request.
  - Emits wb_valid=1, wb_en=0, exception_out_valid=1 after 1 cycle.
  - exception_out = 4 for a load, 6 for a store.
- Without macro: low address bits are forced to natural alignment (half a[0]=0, word a=0) and the access proceeds normally.

Decomposition:
- Shared package/include holds:
  - OP_LOAD, OP_STORE and other opcode constants.
  - F3_LB/LH/LW/LBU/LHU/SB/SH/SW.
  - EX_LOAD_MISALIGNED (4) and EX_STORE_MISALIGNED (6).
  - FSM state encodings.
- One natural sub-module, mem_lane_align: combinational be/wdata generation for stores and lane extraction/extension for loads.

Test Plan:
- ADD result 0x0000_0010, rd=5 -> wb_valid=1, wb_en=1, wb_data=0x10 one cycle later; stall_out never asserted.
- SW addr 0x104, data 0xDEADBEEF, ready delayed 2 cycles -> dmem_addr 0x104, be 4'hF, request held stable 3 cycles; stall_out high until completion; wb_en=0.
- LB addr 0x203, rdata 0x80FF_1234 -> be 4'b1000, wb_data 0xFFFF_FF80; LBU same -> 0x0000_0080.
- SH addr 0x302, data 0x0000_ABCD -> be 4'b1100, wdata 0xABCD_ABCD.
- Reset asserted in WAIT_RSP, then rsp arrives -> no wb_valid; state IDLE; next ADD completes in 1 cycle.
- With MEM_MISALIGN_CHECK_EN, LW addr 0x101 -> no dmem_req_valid, exception_out=4, exception_out_valid=1; without the macro -> dmem_addr 0x100, be 4'hF.
